// File: rtl/gcd_pkg.sv
// ============================================================================
// Module      : gcd_pkg
// Description : Shared state encoding and default operand width for gcd_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;
  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/gcd_datapath.sv
// ============================================================================
// Module      : gcd_datapath
// Description : A/B operand registers, subtractors and comparator for gcd_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             sel_merge,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] a_out,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             zero
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    if (load_a) begin
      a_d = data_in;
    end else if (sel_merge) begin
      // With one operand zero, OR yields the other operand (0 if both zero).
      a_d = a_q | b_q;
    end else if (sub_a) begin
      a_d = a_q - b_q;
    end
  end

  always_comb begin
    b_d = b_q;
    if (load_b) begin
      b_d = data_in;
    end else if (sub_b) begin
      b_d = b_q - a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign eq    = (a_q == b_q);
  assign lt    = (a_q <  b_q);
  assign gt    = (a_q >  b_q);
  assign zero  = (a_q == '0) || (b_q == '0);
  assign a_out = a_q;

endmodule

`default_nettype wire

// File: rtl/gcd_core.sv
// ============================================================================
// Module      : gcd_core
// Description : Subtract-based GCD engine; FSM sequencing gcd_datapath.
//               Optional macro GCD_ITER_COUNT_EN adds the iter_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
`ifdef GCD_ITER_COUNT_EN
  output logic [15:0]      iter_count,
`endif
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   load_a, load_b, sel_merge, sub_a, sub_b;
  logic   eq, lt, gt, zero;

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_a    (load_a),
    .load_b    (load_b),
    .sel_merge (sel_merge),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .data_in   (data_in),
    .a_out     (result),
    .eq        (eq),
    .lt        (lt),
    .gt        (gt),
    .zero      (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_B;
      LOAD_B:  state_d = RUN;
      RUN:     if (zero || eq) state_d = DONE;
      DONE:    if (start) state_d = LOAD_B;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_a    = 1'b0;
    load_b    = 1'b0;
    sel_merge = 1'b0;
    sub_a     = 1'b0;
    sub_b     = 1'b0;
    case (state_q)
      IDLE, DONE: load_a = start;
      LOAD_B:     load_b = 1'b1;
      RUN: begin
        sel_merge = zero;
        sub_a     = !zero && gt;
        sub_b     = !zero && lt;
      end
      default: ;
    endcase
  end

  // done is a flop that tracks the state about to be entered.
  assign done_d = (state_d == DONE);
  assign done   = done_q;

`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_count_q, iter_count_d;

  always_comb begin
    iter_count_d = iter_count_q;
    if (load_a) begin
      iter_count_d = '0;
    end else if ((sub_a || sub_b) && (iter_count_q != 16'hFFFF)) begin
      iter_count_d = iter_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_count_q <= '0;
    end else begin
      iter_count_q <= iter_count_d;
    end
  end

  assign iter_count = iter_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_core.sv
// ============================================================================
// Module      : tb_gcd_core
// Description : Directed, table-driven self-checking bench for gcd_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        done;
  logic [15:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gcd_core #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
`ifdef GCD_ITER_COUNT_EN
    .iter_count (iter_count),
`endif
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          done_edge;
    int          iters;
    bit          hold_start;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one computation starting at edge 0 and checks latency and result.
  task automatic run(input vec_t v, input string name);
    int e;
    start   = 1'b1;
    data_in = v.a;
    tick();
    chk({name, " done_low_e0"}, {31'd0, done}, 32'd0);
    data_in = v.b;
    start   = v.hold_start;
    tick();
    e = 1;
    chk({name, " done_low_e1"}, {31'd0, done}, 32'd0);
    if (v.hold_start) data_in = 16'hABCD;
    while (!done && e < 3000) begin
      tick();
      e++;
    end
    start = 1'b0;
    chk({name, " done_edge"}, e, v.done_edge);
    chk({name, " result"}, {16'd0, result}, {16'd0, v.res});
`ifdef GCD_ITER_COUNT_EN
    chk({name, " iter_count"}, {16'd0, iter_count}, v.iters);
`endif
    tick();
    tick();
    chk({name, " done_hold"}, {31'd0, done}, 32'd1);
    chk({name, " result_hold"}, {16'd0, result}, {16'd0, v.res});
`ifdef GCD_ITER_COUNT_EN
    chk({name, " iter_hold"}, {16'd0, iter_count}, v.iters);
`endif
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'd115,   16'd25,    16'd5,     9,    7,   1'b0};
    vecs[1] = '{16'd48,    16'd18,    16'd6,     6,    4,   1'b0};
    vecs[2] = '{16'd42,    16'd42,    16'd42,    2,    0,   1'b0};
    vecs[3] = '{16'd17,    16'd5,     16'd1,     8,    6,   1'b0};
    vecs[4] = '{16'd25,    16'd115,   16'd5,     9,    7,   1'b0};
    vecs[5] = '{16'd0,     16'd9,     16'd9,     2,    0,   1'b0};
    vecs[6] = '{16'd0,     16'd0,     16'd0,     2,    0,   1'b0};
    vecs[7] = '{16'd9,     16'd0,     16'd9,     2,    0,   1'b0};
    vecs[8] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  2,    0,   1'b0};
    vecs[9] = '{16'd1000,  16'd1,     16'd1,     1001, 999, 1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'd0;
    tick();
    tick();
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", {16'd0, result}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    chk("reset iter_count", {16'd0, iter_count}, 32'd0);
`endif
    rst = 1'b0;

    // IDLE with start low must not capture data_in.
    data_in = 16'd77;
    tick();
    tick();
    chk("idle hold result", {16'd0, result}, 32'd0);
    chk("idle hold done", {31'd0, done}, 32'd0);

    // Back-to-back runs: entries 0 -> 1 also exercise restart from DONE.
    for (int i = 0; i < 10; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high through LOAD_B and RUN, with garbage on data_in.
    run('{16'd115, 16'd25, 16'd5, 9, 7, 1'b1}, "hold_start");

    // Reset in the middle of RUN abandons the computation.
    start   = 1'b1;
    data_in = 16'd115;
    tick();
    data_in = 16'd25;
    start   = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("midrun busy", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun rst done", {31'd0, done}, 32'd0);
    chk("midrun rst result", {16'd0, result}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    chk("midrun rst iter", {16'd0, iter_count}, 32'd0);
`endif
    tick();
    tick();
    chk("post rst idle done", {31'd0, done}, 32'd0);
    chk("post rst idle result", {16'd0, result}, 32'd0);
    run(vecs[1], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
